// File: rtl/ga_pixel_serializer_if.sv
// Video-path bus between the CRTC/CPU side and the gate-array pixel serializer.
// The master drives byte loads, sync and palette writes; the slave returns pixel colour and status.
interface ga_pixel_serializer_if #(
    parameter int COLOR_BITS = 4
);
    logic                      load;
    logic [7:0]                vid_byte;
    logic                      dispen;
    logic                      hsync;
    logic                      force_blank;
    logic [1:0]                mode_req;
    logic                      pal_we;
    logic [4:0]                pal_addr;
    logic [3*COLOR_BITS-1:0]   pal_data;
    logic [3*COLOR_BITS-1:0]   rgb;
    logic [1:0]                cur_mode;
    logic                      underrun;

    modport master (
        output load, vid_byte, dispen, hsync, force_blank, mode_req,
               pal_we, pal_addr, pal_data,
        input  rgb, cur_mode, underrun
    );

    modport slave (
        input  load, vid_byte, dispen, hsync, force_blank, mode_req,
               pal_we, pal_addr, pal_data,
        output rgb, cur_mode, underrun
    );
endinterface

// File: rtl/ga_pixel_serializer.sv
// CPC/Plus gate-array pixel serializer: shifts one video byte out as mode-dependent pixels,
// resolves each pen through a 17-entry palette and registers the RGB result.
module ga_pixel_serializer #(
    parameter int COLOR_BITS  = 4,
    parameter int LOAD_PERIOD = 8,
    parameter int MODE_SYNC   = 1
) (
    input  logic                  clk_16,
    input  logic                  reset,
    ga_pixel_serializer_if.slave  bus
);
    localparam int CW = 3 * COLOR_BITS;
    localparam int PW = (LOAD_PERIOD > 4) ? $clog2(LOAD_PERIOD) : 2;
    localparam logic [PW-1:0] PHASE_MAX  = PW'(LOAD_PERIOD - 1);
    localparam logic [4:0]    PEN_BORDER = 5'd16;
    localparam int            NUM_PENS   = 17;

    logic [7:0]    r_shift;
    logic          r_disp;
    logic [PW-1:0] r_phase;
    logic          r_underrun;
    logic [1:0]    r_cur_mode;
    logic [1:0]    r_pend_mode;
    logic          r_blank_d;
    logic [CW-1:0] r_rgb;
    logic [CW-1:0] r_pal [0:NUM_PENS-1];

    logic          w_sat;
    logic          w_pix_end;
    logic [PW-1:0] w_width_mask;
    logic [4:0]    w_pen;
    logic [CW-1:0] w_pal_rd;

    assign w_sat = (r_phase == PHASE_MAX);

    // Pixel widths are powers of two, so a pixel ends when the low phase bits are all ones.
    always_comb begin
        w_width_mask = PW'(3);
        case (r_cur_mode)
            2'd1:    w_width_mask = PW'(1);
            2'd2:    w_width_mask = PW'(0);
            default: w_width_mask = PW'(3);
        endcase
    end

    assign w_pix_end = ((r_phase & w_width_mask) == w_width_mask);

    always_ff @(posedge clk_16) begin
        if (reset) begin
            r_shift    <= 8'd0;
            r_disp     <= 1'b0;
            r_phase    <= '0;
            r_underrun <= 1'b0;
            r_cur_mode <= 2'd0;
        end else if (bus.load) begin
            r_shift    <= bus.vid_byte;
            r_disp     <= bus.dispen;
            r_phase    <= '0;
            r_underrun <= 1'b0;
            r_cur_mode <= r_pend_mode;
        end else begin
            if (!w_sat) begin
                r_phase <= r_phase + PW'(1);
            end else begin
                r_underrun <= 1'b1;
            end
            if (w_pix_end) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end
        end
    end

    generate
        if (MODE_SYNC != 0) begin : g_hsync_sync
            logic r_hsync_d;
            always_ff @(posedge clk_16) begin
                if (reset) begin
                    r_hsync_d   <= 1'b0;
                    r_pend_mode <= 2'd0;
                end else begin
                    r_hsync_d <= bus.hsync;
                    if (bus.hsync && !r_hsync_d) begin
                        r_pend_mode <= bus.mode_req;
                    end
                end
            end
        end else begin : g_load_sync
            always_ff @(posedge clk_16) begin
                if (reset) begin
                    r_pend_mode <= 2'd0;
                end else if (bus.load) begin
                    r_pend_mode <= bus.mode_req;
                end
            end
        end
    endgenerate

    always_comb begin
        w_pen = PEN_BORDER;
        if (r_disp && !r_underrun) begin
            case (r_cur_mode)
                2'd0:    w_pen = {1'b0, r_shift[1], r_shift[5], r_shift[3], r_shift[7]};
                2'd2:    w_pen = {4'd0, r_shift[7]};
                default: w_pen = {3'd0, r_shift[3], r_shift[7]};
            endcase
        end
    end

    always_ff @(posedge clk_16) begin
        for (int i = 0; i < NUM_PENS; i++) begin
            if (reset) begin
                r_pal[i] <= '0;
            end else if (bus.pal_we && (bus.pal_addr == 5'(i))) begin
                r_pal[i] <= bus.pal_data;
            end
        end
    end

    always_comb begin
        w_pal_rd = '0;
        for (int i = 0; i < NUM_PENS; i++) begin
            if (w_pen == 5'(i)) begin
                w_pal_rd = r_pal[i];
            end
        end
    end

    // The lookup reads the palette before this edge's write, so a same-cycle write shows next lookup.
    always_ff @(posedge clk_16) begin
        if (reset) begin
            r_blank_d <= 1'b0;
            r_rgb     <= '0;
        end else begin
            r_blank_d <= bus.force_blank;
            r_rgb     <= r_blank_d ? '0 : w_pal_rd;
        end
    end

    assign bus.rgb      = r_rgb;
    assign bus.cur_mode = r_cur_mode;
    assign bus.underrun = r_underrun;
endmodule
